// File: rtl/voice_allocator.sv
// voice_allocator: picks a channel for each serialized note-on/off event and drives the note bank write interface; define VOICE_STEAL_EN to steal a voice round-robin instead of dropping when all channels are busy.
module voice_allocator #(
  parameter int NUM_BITS_IN  = 18,
  parameter int NUM_CHANNELS = 16,
  localparam int CH_W = $clog2(NUM_CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [6:0]                 ev_key,
  input  logic [6:0]                 ev_vel,
  input  logic [NUM_BITS_IN-1:0]     ev_inc,
  input  logic [NUM_CHANNELS-1:0]    available,
  output logic [NUM_CHANNELS-1:0]    reg_en,
  output logic [NUM_CHANNELS-1:0]    note_en,
  output logic [NUM_BITS_IN-1:0]     note_out,
  output logic [NUM_CHANNELS*32-1:0] velocity_out,
  output logic                       drop
);
  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;
  state_t state_q, state_d;
  logic on_q, on_d;
  logic [6:0] ev_key_q, ev_key_d, ev_vel_q, ev_vel_d;
  logic [NUM_BITS_IN-1:0] ev_inc_q, ev_inc_d, note_out_q, note_out_d;
  logic match_hit_q, match_hit_d, free_hit_q, free_hit_d, wr;
  logic [CH_W-1:0] match_ch_q, match_ch_d, free_ch_q, free_ch_d, ch;
  logic [NUM_CHANNELS-1:0] note_en_q, note_en_d;
  logic [6:0] key_q [NUM_CHANNELS];
  logic [6:0] key_d [NUM_CHANNELS];
  logic [6:0] vel_q [NUM_CHANNELS];
  logic [6:0] vel_d [NUM_CHANNELS];
`ifdef VOICE_STEAL_EN
  logic [CH_W-1:0] steal_ptr_q, steal_ptr_d;
`endif
  // Sequencing, channel search and the commit action for one event at a time
  always_comb begin
    state_d = state_q;
    on_d = on_q;
    ev_key_d = ev_key_q;
    ev_vel_d = ev_vel_q;
    ev_inc_d = ev_inc_q;
    match_hit_d = match_hit_q;
    match_ch_d = match_ch_q;
    free_hit_d = free_hit_q;
    free_ch_d = free_ch_q;
    note_en_d = note_en_q;
    key_d = key_q;
    vel_d = vel_q;
    note_out_d = note_out_q;
`ifdef VOICE_STEAL_EN
    steal_ptr_d = steal_ptr_q;
`endif
    ev_ready = 1'b0;
    drop = 1'b0;
    wr = 1'b0;
    ch = '0;
    reg_en = '0;
    case (state_q)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          on_d = ev_on;
          ev_key_d = ev_key;
          ev_vel_d = ev_vel;
          ev_inc_d = ev_inc;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        match_hit_d = 1'b0;
        match_ch_d = '0;
        free_hit_d = 1'b0;
        free_ch_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (!match_hit_d && note_en_q[c] && key_q[c] == ev_key_q) begin
            match_hit_d = 1'b1;
            match_ch_d = CH_W'(c);
          end
          if (!free_hit_d && available[c] && !note_en_q[c]) begin
            free_hit_d = 1'b1;
            free_ch_d = CH_W'(c);
          end
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          wr = 1'b1;
          if (match_hit_q) ch = match_ch_q;
          else if (free_hit_q) ch = free_ch_q;
          else begin
`ifdef VOICE_STEAL_EN
            ch = steal_ptr_q;
            steal_ptr_d = steal_ptr_q + 1'b1;
`else
            wr = 1'b0;
            drop = 1'b1;
`endif
          end
        end else if (match_hit_q) note_en_d[match_ch_q] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (wr) begin
      reg_en[ch] = 1'b1;
      note_en_d[ch] = 1'b1;
      key_d[ch] = ev_key_q;
      vel_d[ch] = ev_vel_q;
      note_out_d = ev_inc_q;
    end
  end
  // State and bank-shadow registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      on_q <= 1'b0;
      ev_key_q <= '0;
      ev_vel_q <= '0;
      ev_inc_q <= '0;
      match_hit_q <= 1'b0;
      match_ch_q <= '0;
      free_hit_q <= 1'b0;
      free_ch_q <= '0;
      note_en_q <= '0;
      key_q <= '{default: '0};
      vel_q <= '{default: '0};
      note_out_q <= '0;
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      on_q <= on_d;
      ev_key_q <= ev_key_d;
      ev_vel_q <= ev_vel_d;
      ev_inc_q <= ev_inc_d;
      match_hit_q <= match_hit_d;
      match_ch_q <= match_ch_d;
      free_hit_q <= free_hit_d;
      free_ch_q <= free_ch_d;
      note_en_q <= note_en_d;
      key_q <= key_d;
      vel_q <= vel_d;
      note_out_q <= note_out_d;
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= steal_ptr_d;
`endif
    end
  end
  assign note_en = note_en_q;
  assign note_out = wr ? ev_inc_q : note_out_q;
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_vel
    assign velocity_out[32*g +: 32] = {25'b0, vel_q[g]};
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized and directed checks of voice_allocator against an event-level channel model.
module tb_voice_allocator;
  localparam int NC = 16;
  localparam int NB = 18;
  logic clk = 1'b0, rst_n = 1'b0, ev_valid = 1'b0, ev_on = 1'b0;
  logic [6:0] ev_key = '0, ev_vel = '0;
  logic [NB-1:0] ev_inc = '0;
  logic [NC-1:0] available = '1;
  logic ev_ready, drop;
  logic [NC-1:0] reg_en, note_en;
  logic [NB-1:0] note_out;
  logic [NC*32-1:0] velocity_out;
  int n_cmp = 0, n_fail = 0;
  bit m_gate [NC];
  logic [6:0] m_key [NC];
  logic [6:0] m_vel [NC];
  logic [NB-1:0] m_last;
  int m_ptr;
  logic [NC-1:0] obs_reg;
  voice_allocator #(.NUM_BITS_IN(NB), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_key(ev_key), .ev_vel(ev_vel), .ev_inc(ev_inc), .available(available),
    .reg_en(reg_en), .note_en(note_en), .note_out(note_out), .velocity_out(velocity_out), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_gate[c] = 0;
      m_key[c] = '0;
      m_vel[c] = '0;
    end
    m_last = '0;
    m_ptr = 0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ev_valid = 1'b0;
    available = '1;
    model_clear();
    #1;
    n_cmp++; if (reg_en !== '0 || note_en !== '0 || note_out !== '0 || drop !== 1'b0) begin n_fail++; $display("FAIL reset_outs reg_en=%h note_en=%h note_out=%h drop=%b exp all 0", reg_en, note_en, note_out, drop); end
    n_cmp++; if (velocity_out !== '0 || ev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_vel_ready vel_nonzero=%b ready=%b exp 0/1", |velocity_out, ev_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic do_event(input bit on, input logic [6:0] k, input logic [6:0] v, input logic [NB-1:0] inc);
    int w = 0, mt = -1, fr = -1, ch = -1;
    bit drp = 0;
    logic [NC-1:0] av, e_reg, e_gate;
    logic [NB-1:0] e_no;
    logic [NC*32-1:0] e_vel;
    @(negedge clk);
    while (ev_ready !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    n_cmp++; if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL ready_wait got=%b exp=1", ev_ready); end
    ev_valid = 1'b1; ev_on = on; ev_key = k; ev_vel = v; ev_inc = inc;
    @(negedge clk);
    ev_valid = 1'b0; ev_on = 1'($urandom); ev_key = 7'($urandom); ev_vel = 7'($urandom); ev_inc = NB'($urandom);
    n_cmp++; if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL ready_lookup got=%b exp=0", ev_ready); end
    av = available;
    for (int c = 0; c < NC; c++) begin
      if (mt < 0 && m_gate[c] && m_key[c] == k) mt = c;
      if (fr < 0 && av[c] && !m_gate[c]) fr = c;
    end
    if (on) begin
      if (mt >= 0) ch = mt;
      else if (fr >= 0) ch = fr;
      else begin
`ifdef VOICE_STEAL_EN
        ch = m_ptr;
        m_ptr = (m_ptr + 1) % NC;
`else
        drp = 1;
`endif
      end
    end else if (mt >= 0) m_gate[mt] = 0;
    e_reg = (ch >= 0) ? NC'(1) << ch : '0;
    e_no = (ch >= 0) ? inc : m_last;
    @(negedge clk);
    available = NC'($urandom);
    #1;
    obs_reg = reg_en;
    n_cmp++; if (reg_en !== e_reg) begin n_fail++; $display("FAIL commit_reg_en got=%h exp=%h", reg_en, e_reg); end
    n_cmp++; if (note_out !== e_no) begin n_fail++; $display("FAIL commit_note_out got=%h exp=%h", note_out, e_no); end
    n_cmp++; if (drop !== drp) begin n_fail++; $display("FAIL commit_drop got=%b exp=%b", drop, drp); end
    available = av;
    if (ch >= 0) begin
      m_gate[ch] = 1;
      m_key[ch] = k;
      m_vel[ch] = v;
      m_last = inc;
    end
    for (int c = 0; c < NC; c++) begin
      e_gate[c] = m_gate[c];
      e_vel[32*c +: 32] = {25'b0, m_vel[c]};
    end
    @(negedge clk);
    n_cmp++; if (note_en !== e_gate) begin n_fail++; $display("FAIL note_en got=%h exp=%h", note_en, e_gate); end
    n_cmp++; if (velocity_out !== e_vel) begin n_fail++; $display("FAIL velocity_out got=%h exp=%h", velocity_out, e_vel); end
    n_cmp++; if (ev_ready !== 1'b1 || reg_en !== '0 || drop !== 1'b0) begin n_fail++; $display("FAIL post_commit ready=%b reg_en=%h drop=%b exp 1/0/0", ev_ready, reg_en, drop); end
  endtask
  task automatic test_basic();
    test_reset();
    do_event(1, 7'd60, 7'd100, 18'h1234);
    n_cmp++; if (obs_reg !== 16'h0001) begin n_fail++; $display("FAIL first_on_ch0 got=%h exp=0001", obs_reg); end
    n_cmp++; if (velocity_out[31:0] !== 32'd100) begin n_fail++; $display("FAIL first_vel got=%0d exp=100", velocity_out[31:0]); end
    do_event(1, 7'd64, 7'd90, 18'h2345);
    n_cmp++; if (obs_reg !== 16'h0002) begin n_fail++; $display("FAIL second_on_ch1 got=%h exp=0002", obs_reg); end
    do_event(0, 7'd60, 7'd0, 18'h0);
    n_cmp++; if (note_en !== 16'h0002) begin n_fail++; $display("FAIL off60 note_en got=%h exp=0002", note_en); end
    do_event(0, 7'd70, 7'd0, 18'h0);
    do_event(1, 7'd64, 7'd0, 18'h3456);
    n_cmp++; if (obs_reg !== 16'h0002) begin n_fail++; $display("FAIL retrigger got=%h exp=0002", obs_reg); end
  endtask
  task automatic test_unavailable();
    available = 16'hFFFE;
    do_event(1, 7'd50, 7'd33, 18'h0ABC);
    n_cmp++; if (obs_reg !== 16'h0004) begin n_fail++; $display("FAIL skip_ch0 got=%h exp=0004", obs_reg); end
    available = '1;
  endtask
  task automatic test_full();
    test_reset();
    for (int i = 0; i < NC; i++) do_event(1, 7'(20 + i), 7'(i + 1), NB'(i * 7));
    do_event(1, 7'd80, 7'd127, 18'h3FFFF);
    do_event(1, 7'd81, 7'd1, 18'h00001);
  endtask
  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      available = ($urandom_range(3) == 0) ? NC'($urandom) : '1;
      do_event($urandom_range(9) < 6, 7'(60 + $urandom_range(11)), 7'($urandom), NB'($urandom));
    end
    available = '1;
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd99; ev_vel = 7'd5; ev_inc = 18'h155;
    @(negedge clk);
    ev_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (note_en !== '0 || reg_en !== '0 || note_out !== '0 || velocity_out !== '0 || drop !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outs note_en=%h reg_en=%h note_out=%h drop=%b exp 0", note_en, reg_en, note_out, drop); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ev_ready !== 1'b1 || note_en !== '0) begin n_fail++; $display("FAIL mid_reset_release ready=%b note_en=%h exp 1/0", ev_ready, note_en); end
    do_event(1, 7'd45, 7'd77, 18'h2A2A);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_unavailable();
    test_full();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
